// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the multicycle divider and multiplier control.
// Holds the divider state encoding and common width constants.
package cpu_pkg;

    localparam int WORD_W      = 32;
    localparam int DIV_COUNT_W = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
// Shifts {rem,quo} left and subtracts the divisor when it fits.
module div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   div_ext;

    assign div_ext = {1'b0, div_i};
    assign shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
    assign trial   = shifted - div_ext;

    // Keep the trial difference only when the divisor fits.
    always_comb begin
        rem_o = shifted;
        quo_o = {quo_i[WIDTH-2:0], 1'b0};
        if (shifted >= div_ext) begin
            rem_o    = trial;
            quo_o[0] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_div32.sv
// Multicycle signed divider: restoring divide on magnitudes, then sign fix-up.
// Quotient goes to LO, remainder to HI, with a one-cycle done pulse.
module seq_div32
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [DIV_COUNT_W-1:0] LAST = DIV_COUNT_W'(WIDTH - 1);

    div_state_e             state_q, state_d;
    logic [WIDTH:0]         rem_q, rem_d;
    logic [WIDTH-1:0]       quo_q, quo_d;
    logic [WIDTH-1:0]       div_q, div_d;
    logic [DIV_COUNT_W-1:0] cnt_q, cnt_d;
    logic                   qneg_q, qneg_d;
    logic                   rneg_q, rneg_d;
    logic                   dz_q, dz_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;

    logic [WIDTH:0]         step_rem;
    logic [WIDTH-1:0]       step_quo;
    logic [WIDTH-1:0]       dvd_abs;
    logic [WIDTH-1:0]       dvs_abs;
    logic [WIDTH-1:0]       rem_w;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // The most negative value maps to itself, which reads correctly as unsigned.
    assign dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_abs = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign rem_w   = rem_q[WIDTH-1:0];

    // Register all state; reset clears everything asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= DIV_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state and datapath updates for accept, iterate, fix-up and done.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        state_d = DIV_DONE;
                    end else begin
                        quo_d   = dvd_abs;
                        div_d   = dvs_abs;
                        rem_d   = '0;
                        qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rneg_d  = dividend[WIDTH-1];
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                        state_d = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                lo_d    = qneg_q ? -quo_q : quo_q;
                hi_d    = rneg_q ? -rem_w : rem_w;
                dz_d    = 1'b0;
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    assign busy     = (state_q == DIV_RUN) || (state_q == DIV_FIX);
    assign done     = (state_q == DIV_DONE);
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_seq_div32.sv
// Self-checking bench for seq_div32: cycle-level reference model plus
// directed operand vectors with hand-computed results.
module tb_seq_div32;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    localparam int NONE = 1000;

    seq_div32 dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles since acceptance (0 = idle, 34 = done cycle).
    int          m_cyc;
    logic [31:0] m_lo, m_hi, p_lo, p_hi;
    logic        m_dz;

    always @(posedge clock or negedge reset) begin
        longint sa, sb, q, r;
        if (!reset) begin
            m_cyc = 0;
            m_lo  = 0;
            m_hi  = 0;
            m_dz  = 0;
        end else if (m_cyc == 0) begin
            if (start) begin
                if (divisor == 0) begin
                    m_dz  = 1;
                    m_cyc = 34;
                end else begin
                    sa    = longint'($signed(dividend));
                    sb    = longint'($signed(divisor));
                    q     = sa / sb;
                    r     = sa % sb;
                    p_lo  = q[31:0];
                    p_hi  = r[31:0];
                    m_dz  = 0;
                    m_cyc = 1;
                end
            end
        end else if (m_cyc == 34) begin
            m_cyc = 0;
        end else begin
            m_cyc++;
            if (m_cyc == 34) begin
                m_lo = p_lo;
                m_hi = p_hi;
            end
        end
    end

    // Compare every cycle away from the active edge.
    always @(negedge clock) begin
        chk("busy", 32'(busy), 32'(m_cyc >= 1 && m_cyc <= 33));
        chk("done", 32'(done), 32'(m_cyc == 34));
        chk("div_zero", 32'(div_zero), 32'(m_dz));
        chk("lo", lo, m_lo);
        chk("hi", hi, m_hi);
    end

    int          r_n;
    int          r_first;
    logic [31:0] r_lo, r_hi;
    logic        r_dz;
    logic        r_busy;

    // Start an operation in cycle 0 and observe cycles 0..45.
    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input int pulse_at, input int rst_at);
        r_n     = 0;
        r_first = -1;
        r_lo    = 'x;
        r_hi    = 'x;
        r_dz    = 1'bx;
        r_busy  = 0;
        @(posedge clock);
        #1;
        start    = 1;
        dividend = a;
        divisor  = b;
        for (int n = 0; n <= 45; n++) begin
            if (n > 0) begin
                @(posedge clock);
                #1;
                start = (n == pulse_at);
                if (n == pulse_at) begin
                    dividend = 9;
                    divisor  = 3;
                end else begin
                    dividend = $urandom;
                    divisor  = $urandom;
                end
            end
            if (n == rst_at) begin
                reset = 0;
                #1;
                chk("async_busy", 32'(busy), 0);
                chk("async_done", 32'(done), 0);
                chk("async_dz", 32'(div_zero), 0);
                chk("async_lo", lo, 0);
                chk("async_hi", hi, 0);
            end
            if (n == rst_at + 2) reset = 1;
            @(negedge clock);
            if (busy) r_busy = 1;
            if (done) begin
                r_n++;
                if (r_first < 0) begin
                    r_first = n;
                    r_lo    = lo;
                    r_hi    = hi;
                    r_dz    = div_zero;
                end
            end
        end
        start = 0;
    endtask

    task automatic expect_op(input string nm, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] elo,
                             input logic [31:0] ehi);
        run(a, b, NONE, NONE);
        chk({nm, "_ndone"}, r_n, 1);
        chk({nm, "_lat"}, r_first, 34);
        chk({nm, "_lo"}, r_lo, elo);
        chk({nm, "_hi"}, r_hi, ehi);
        chk({nm, "_dz"}, 32'(r_dz), 0);
    endtask

    initial begin
        reset    = 0;
        start    = 0;
        dividend = 0;
        divisor  = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_lo", lo, 0);
        chk("rst_hi", hi, 0);
        reset = 1;

        expect_op("p100_7", 100, 7, 14, 2);
        chk("p100_7_busy", 32'(r_busy), 1);
        expect_op("n100_7", -100, 7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        expect_op("p100_n7", 100, -7, 32'hFFFF_FFF2, 2);
        expect_op("n100_n7", -100, -7, 14, 32'hFFFF_FFFE);

        expect_op("pre_zero", 100, 7, 14, 2);
        run(5, 0, NONE, NONE);
        chk("zero_ndone", r_n, 1);
        chk("zero_lat", r_first, 1);
        chk("zero_dz", 32'(r_dz), 1);
        chk("zero_busy", 32'(r_busy), 0);
        chk("zero_lo", r_lo, 14);
        chk("zero_hi", r_hi, 2);

        expect_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        expect_op("max_1", 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 0);
        expect_op("p3_10", 3, 10, 0, 3);

        run(100, 7, 5, NONE);
        chk("repulse_ndone", r_n, 1);
        chk("repulse_lat", r_first, 34);
        chk("repulse_lo", r_lo, 14);
        chk("repulse_hi", r_hi, 2);

        run(100, 7, NONE, 10);
        chk("abort_ndone", r_n, 0);
        chk("abort_lo", lo, 0);
        expect_op("after_rst", 9, 3, 3, 0);

        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_div32.md
Name: seq_div32

Overview:
- Multicycle signed 32-bit divider. It is the responder on the CPU's Use_Div / HI / LO / done / divZero handshake.
- The control unit pulses start with operands from registers A and B. The block runs a radix-2 restoring divide on operand magnitudes, applies sign fix-up, and returns quotient (LO) and remainder (HI) with a one-cycle done pulse.
- It sits beside the multiplier. Its outputs feed the HI/LO register inputs and the load enables.

Parameters:
- WIDTH, 32, operand/result width in bits. Only 32 is verified; the iteration count equals WIDTH.

Ports:
- clock  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- dividend  in  WIDTH  signed two's complement (from A)
- divisor  in  WIDTH  signed two's complement (from B)
- busy  out  1  high from the edge after start is accepted until done
- done  out  1  one-cycle pulse; hi/lo/div_zero valid
- div_zero  out  1  set with done when divisor was 0
- hi  out  WIDTH  remainder
- lo  out  WIDTH  quotient

Behaviour:
- One clock. Reset is asynchronous and active-low: while reset=0, state=IDLE and busy=done=div_zero=0, hi=lo=0, all internal registers 0.
- Reset deasserting mid-operation has no special handling: the block comes up in IDLE. A reset during RUN/FIX aborts the operation with no done.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1, divisor!=0 (edge k):
  - Latch |dividend| into the quotient shift register.
  - Latch |divisor| (unsigned, WIDTH bits) into the divisor register.
  - Clear the remainder register (WIDTH+1 bits).
  - Latch the sign bits: q_neg = dividend[31]^divisor[31]; r_neg = dividend[31].
  - Set count=0, move to RUN.
- IDLE, start=1, divisor==0 (edge k):
  - Move to DONE with div_zero=1.
  - hi/lo keep their previous values.
  - done is high in the cycle after edge k.
- RUN: each edge performs one restoring step.
  - Shift {rem,quo} left 1.
  - trial = rem - div.
  - If trial is non-negative, rem=trial and quo[0]=1; else quo[0]=0.
  - count increments. The 32nd step (count==31) moves to FIX.
- FIX (edge k+33):
  - lo = q_neg ? -quo : quo; hi = r_neg ? -rem : rem. Both are truncated to WIDTH.
  - div_zero=0. Move to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
  - done is high in the cycle following edge k+33, i.e. latency 34 cycles from the start cycle.
- Semantics:
  - Quotient truncates toward zero.
  - Remainder is 0 or has the dividend's sign.
  - |hi| < |divisor|.
- Overflow case -2^31 / -1:
  - |dividend| = 0x80000000 as unsigned; result is lo=0x80000000, hi=0. No flag.
- Handshake:
  - start while busy or in DONE is ignored; it is not queued.
  - Operands are only sampled at the accepting edge. Later changes have no effect.
- Hold behaviour:
  - hi/lo hold their values until the next FIX or reset.
  - div_zero holds its value until the next accepted start (cleared at acceptance) or reset.
- busy = (state==RUN || state==FIX).

Decomposition:
- Shared package cpu_pkg:
  - state encoding constants DIV_IDLE/DIV_RUN/DIV_FIX/DIV_DONE (2 bits)
  - DIV_COUNT_W=5
  - WORD_W=32, for reuse by the multiplier's start/done logic
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, quo, div. Outputs: next rem, next quo.
  - Instantiated once in RUN datapath.
- Sign fix-up: inline negation in the top module.

Test Plan:
- 100 / 7: start in cycle 0 → busy cycles 1..33, done high only in cycle 34, lo=14, hi=2, div_zero=0.
- -100 / 7 → lo=0xFFFFFFF2, hi=0xFFFFFFFE. Also 100 / -7 → lo=0xFFFFFFF2, hi=2. Also -100 / -7 → lo=14, hi=0xFFFFFFFE.
- Previous result lo=14, hi=2, then 5 / 0 → done and div_zero high in cycle 1, busy never high, lo=14, hi=2 unchanged. A following valid start clears div_zero.
- 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. Also 0x7FFFFFFF / 1 → lo=0x7FFFFFFF, hi=0. Also 3 / 10 → lo=0, hi=3.
- start 100/7, re-pulse start with 9/3 in cycle 5 → ignored: done in cycle 34 with lo=14, hi=2, and only one done pulse.
- start 100/7, pull reset low in cycle 10 for 2 cycles → hi/lo/busy/done/div_zero = 0 immediately (asynchronous), no done afterward. A new start 9/3 yields lo=3, hi=0, 34 cycles later.
